// File: rtl/axis_lane_accum_pkg.sv
// axis_lane_accum_pkg
// Shared types and elaboration-time helpers for the lane accumulator.
// Contents:
//   state_t     - frame controller states (IDLE, RUN, DRAIN, DONE)
//   clog2       - ceiling log2, used to size the reduction tree
//   lane_count  - number of W-bit lanes in a B-bit beat (N)
//   tree_width  - full-growth width of the per-beat total (TW = 2W + clog2(N))
//   sat_max/min - signed limits of an acc_w-bit accumulator
package axis_lane_accum_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    function automatic int lane_count(input int b, input int w);
        return b / w;
    endfunction

    // Squares need 2W bits; summing N of them adds clog2(N) bits of growth.
    function automatic int tree_width(input int w, input int n);
        return 2 * w + clog2(n);
    endfunction

    function automatic longint sat_max(input int acc_w);
        return (longint'(1) <<< (acc_w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int acc_w);
        return -(longint'(1) <<< (acc_w - 1));
    endfunction

endpackage

// File: rtl/axis_lane_accum_tree.sv
// lane_adder_tree
// Two-stage per-beat datapath: unpack N signed lanes, optionally square them
// (stage 1), then reduce them to one full-width signed total (stage 2).
// Ports:
//   clk, rstn   - clock, synchronous active-low reset (clears valids only)
//   in_valid    - beat accepted this cycle
//   in_data     - N packed W-bit two's complement lanes
//   mode        - 0 = lane values, 1 = squared lane values
//   mid_valid   - stage 1 holds a beat
//   out_valid   - stage 2 holds a beat (out_sum is valid)
//   out_sum     - signed total of the beat, TW bits, never truncated
module lane_adder_tree
    import axis_lane_accum_pkg::*;
#(
    parameter int W  = 8,
    parameter int N  = 8,
    parameter int TW = tree_width(W, N)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    input  logic [N*W-1:0]       in_data,
    input  logic                 mode,
    output logic                 mid_valid,
    output logic                 out_valid,
    output logic signed [TW-1:0] out_sum
);

    localparam int W2 = 2 * W;

    logic signed [W2-1:0] lane_ext [N];
    logic signed [W2-1:0] stage1   [N];
    logic signed [TW-1:0] tree_total;

    // Lanes are widened to 2W before squaring so the product never wraps.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            lane_ext[k] = W2'($signed(in_data[k*W +: W]));
        end
    end

    always_comb begin
        tree_total = '0;
        for (int k = 0; k < N; k++) begin
            tree_total = tree_total + TW'(stage1[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            mid_valid <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            mid_valid <= in_valid;
            out_valid <= mid_valid;
        end
    end

    // Data registers only load on a valid beat; they need no reset because
    // the valid shift register qualifies them.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            for (int k = 0; k < N; k++) begin
                stage1[k] <= mode ? (lane_ext[k] * lane_ext[k]) : lane_ext[k];
            end
        end
        if (mid_valid) begin
            out_sum <= tree_total;
        end
    end

endmodule

// File: rtl/axis_lane_accum.sv
// axis_lane_accum
// AXI-Stream lane reducer: each accepted beat is reduced (sum or sum of
// squares of its signed lanes) and accumulated over a frame into a wide,
// optionally saturating register.
// Ports:
//   clk, rstn      - clock, synchronous active-low reset
//   s_axis_*       - input stream (tdata lanes, tvalid, tready, tlast)
//   start          - one-cycle pulse starting a frame (honoured in IDLE only)
//   mode           - 0 = sum, 1 = sum of squares (latched at start)
//   num_beats      - frame length, 0 = end on tlast only (latched at start)
//   busy           - frame in progress
//   done           - one-cycle pulse once sum includes the final beat
//   sum            - accumulated result
//   beat_count     - beats accepted in the current/last frame
//   overflow       - sticky saturation/wrap flag for the current frame
module axis_lane_accum
    import axis_lane_accum_pkg::*;
#(
    parameter int B     = 64,
    parameter int W     = 8,
    parameter int ACC_W = 32,
    parameter int CNT_W = 32,
    parameter int SAT   = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [B-1:0]     s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    input  logic             start,
    input  logic             mode,
    input  logic [CNT_W-1:0] num_beats,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] sum,
    output logic [CNT_W-1:0] beat_count,
    output logic             overflow
);

    localparam int N  = lane_count(B, W);
    localparam int TW = tree_width(W, N);
    // The add must hold both the accumulator and a tree total, which can be
    // wider than the accumulator when ACC_W is small.
    localparam int SW = ((ACC_W > TW) ? ACC_W : TW) + 1;
    localparam logic signed [SW-1:0] SAT_HI = SW'(sat_max(ACC_W));
    localparam logic signed [SW-1:0] SAT_LO = SW'(sat_min(ACC_W));

    state_t               state;
    logic                 mode_q;
    logic [CNT_W-1:0]     num_q;
    logic                 accept;
    logic                 last_beat;
    logic                 mid_valid;
    logic                 tree_valid;
    logic signed [TW-1:0] tree_sum;
    logic signed [SW-1:0] acc_ext;
    logic signed [SW-1:0] add_ext;
    logic signed [SW-1:0] acc_sum;
    logic                 out_of_range;
    logic [ACC_W-1:0]     acc_next;

    assign accept    = s_axis_tvalid && s_axis_tready;
    // tlast and a length match on the same beat are one termination.
    assign last_beat = s_axis_tlast ||
                       ((num_q != '0) && ((beat_count + CNT_W'(1)) == num_q));
    assign busy      = (state != IDLE);

    lane_adder_tree #(
        .W  (W),
        .N  (N),
        .TW (TW)
    ) u_tree (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (accept),
        .in_data   (s_axis_tdata),
        .mode      (mode_q),
        .mid_valid (mid_valid),
        .out_valid (tree_valid),
        .out_sum   (tree_sum)
    );

    always_comb begin
        acc_ext      = SW'(signed'(sum));
        add_ext      = SW'(tree_sum);
        acc_sum      = acc_ext + add_ext;
        out_of_range = (acc_sum > SAT_HI) || (acc_sum < SAT_LO);
        acc_next     = acc_sum[ACC_W-1:0];
        if ((SAT != 0) && out_of_range) begin
            acc_next = acc_sum[SW-1] ? SAT_LO[ACC_W-1:0] : SAT_HI[ACC_W-1:0];
        end
    end

    // Frame controller. tready is registered from the next state, so it
    // drops in the cycle after the terminating beat.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= IDLE;
            s_axis_tready <= 1'b0;
            done          <= 1'b0;
            sum           <= '0;
            beat_count    <= '0;
            overflow      <= 1'b0;
            mode_q        <= 1'b0;
            num_q         <= '0;
        end else begin
            done <= 1'b0;
            if (tree_valid) begin
                sum <= acc_next;
                if (out_of_range) begin
                    overflow <= 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q        <= mode;
                        num_q         <= num_beats;
                        sum           <= '0;
                        beat_count    <= '0;
                        overflow      <= 1'b0;
                        s_axis_tready <= 1'b1;
                        state         <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        beat_count <= beat_count + CNT_W'(1);
                        if (last_beat) begin
                            s_axis_tready <= 1'b0;
                            state         <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Stage 2 empties into sum on this same edge, so once
                    // stage 1 is empty the next cycle's sum is final.
                    if (!mid_valid) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_lane_accum.sv
// tb_axis_lane_accum
// Drives three instances (default, 16-bit saturating, 16-bit wrapping) with
// the same stream and compares results against a frame-level model.
module tb_axis_lane_accum;

    localparam int B     = 64;
    localparam int W     = 8;
    localparam int LANES = B / W;
    localparam int CNT_W = 32;

    logic             clk;
    logic             rstn;
    logic [B-1:0]     tdata;
    logic             tvalid;
    logic             tlast;
    logic             start;
    logic             mode;
    logic [CNT_W-1:0] num_beats;

    logic             tready0, busy0, done0, ovf0;
    logic [31:0]      sum0;
    logic [CNT_W-1:0] bc0;
    logic             tready1, busy1, done1, ovf1;
    logic [15:0]      sum1;
    logic [CNT_W-1:0] bc1;
    logic             tready2, busy2, done2, ovf2;
    logic [15:0]      sum2;
    logic [CNT_W-1:0] bc2;

    int tests;
    int failed;

    logic [B-1:0] q_data[$];
    bit           q_last[$];

    bit               timed_out;
    bit               tready_after;
    bit               done_after;
    logic [31:0]      got_sum0;
    logic [15:0]      got_sum1;
    logic [15:0]      got_sum2;
    logic [CNT_W-1:0] got_bc0;
    bit               got_ovf0, got_ovf1, got_ovf2;

    axis_lane_accum #(.B(B), .W(W), .ACC_W(32), .CNT_W(CNT_W), .SAT(1)) dut0 (
        .clk(clk), .rstn(rstn), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
        .s_axis_tready(tready0), .s_axis_tlast(tlast), .start(start), .mode(mode),
        .num_beats(num_beats), .busy(busy0), .done(done0), .sum(sum0),
        .beat_count(bc0), .overflow(ovf0)
    );

    axis_lane_accum #(.B(B), .W(W), .ACC_W(16), .CNT_W(CNT_W), .SAT(1)) dut1 (
        .clk(clk), .rstn(rstn), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
        .s_axis_tready(tready1), .s_axis_tlast(tlast), .start(start), .mode(mode),
        .num_beats(num_beats), .busy(busy1), .done(done1), .sum(sum1),
        .beat_count(bc1), .overflow(ovf1)
    );

    axis_lane_accum #(.B(B), .W(W), .ACC_W(16), .CNT_W(CNT_W), .SAT(0)) dut2 (
        .clk(clk), .rstn(rstn), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
        .s_axis_tready(tready2), .s_axis_tlast(tlast), .start(start), .mode(mode),
        .num_beats(num_beats), .busy(busy2), .done(done2), .sum(sum2),
        .beat_count(bc2), .overflow(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Value contributed by one beat: plain integer sum of lanes or squares.
    function automatic longint beat_value(input logic [B-1:0] d, input bit m);
        longint total;
        total = 0;
        for (int k = 0; k < LANES; k++) begin
            longint x;
            x = longint'($signed(d[k*W +: W]));
            total = total + (m ? x * x : x);
        end
        return total;
    endfunction

    // Running total of the queued frame in an acc_w-bit signed register.
    task automatic model_frame(input bit m, input int acc_w, input bit sat,
                               output longint s, output bit ovf);
        longint hi, lo, span;
        hi   = (longint'(1) <<< (acc_w - 1)) - 1;
        lo   = -hi - 1;
        span = longint'(1) <<< acc_w;
        s    = 0;
        ovf  = 0;
        foreach (q_data[i]) begin
            s = s + beat_value(q_data[i], m);
            if (s > hi || s < lo) begin
                ovf = 1;
                if (sat) s = (s > hi) ? hi : lo;
                else begin
                    s = (s - lo) % span;
                    if (s < 0) s = s + span;
                    s = s + lo;
                end
            end
        end
    endtask

    // Runs one frame from the queues; leaves time in the cycle after done.
    task automatic drive_frame(input bit m, input logic [CNT_W-1:0] nb,
                               input int gmin, input int gmax, input int restart_at);
        int waitc;
        int g;
        timed_out = 0;
        start = 1; mode = m; num_beats = nb;
        @(posedge clk); #1;
        start = 0;
        for (int i = 0; i < q_data.size(); i++) begin
            if (i == restart_at) begin
                start = 1; mode = ~m; num_beats = 1;
            end
            tdata = q_data[i]; tlast = q_last[i]; tvalid = 1;
            waitc = 0;
            forever begin
                bit acc_now;
                acc_now = tready0;
                @(posedge clk); #1;
                start = 0; mode = m; num_beats = nb;
                if (acc_now) break;
                waitc++;
                if (waitc > 20) begin
                    timed_out = 1;
                    break;
                end
            end
            tvalid = 0; tlast = 0;
            if (timed_out) break;
            if (i == q_data.size() - 1) tready_after = tready0;
            else begin
                g = int'($urandom_range(gmax, gmin));
                repeat (g) begin
                    @(posedge clk); #1;
                end
            end
        end
        waitc = 0;
        while (!timed_out && !done0 && waitc < 40) begin
            @(posedge clk); #1;
            waitc++;
        end
        if (!done0) timed_out = 1;
        got_sum0 = sum0; got_sum1 = sum1; got_sum2 = sum2; got_bc0 = bc0;
        got_ovf0 = ovf0; got_ovf1 = ovf1; got_ovf2 = ovf2;
        @(posedge clk); #1;
        done_after = done0;
    endtask

    task automatic fill_const(input logic [B-1:0] d, input int len, input bit last_on_end);
        q_data.delete(); q_last.delete();
        for (int i = 0; i < len; i++) begin
            q_data.push_back(d);
            q_last.push_back(last_on_end && (i == len - 1));
        end
    endtask

    task automatic test_reset;
        rstn = 0; tvalid = 0; tlast = 0; start = 0; mode = 0; num_beats = 0; tdata = '0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if ({busy0, tready0, done0, ovf0} !== 4'b0) begin failed++; $display("[TB] FAIL reset_flags: got %b want 0000", {busy0, tready0, done0, ovf0}); end
        tests++; if (sum0 !== 32'd0 || bc0 !== 32'd0) begin failed++; $display("[TB] FAIL reset_sum: got sum %0d count %0d want 0 0", sum0, bc0); end
        tests++; if ({busy1, busy2, sum1, sum2} !== 34'd0) begin failed++; $display("[TB] FAIL reset_narrow: got %h want 0", {busy1, busy2, sum1, sum2}); end
        rstn = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_sum_basic;
        fill_const(64'h0101010101010101, 4, 0);
        drive_frame(0, 4, 0, 0, -1);
        tests++; if (timed_out !== 0) begin failed++; $display("[TB] FAIL basic_timeout: got %0d want 0", timed_out); end
        tests++; if (tready_after !== 0) begin failed++; $display("[TB] FAIL basic_tready_drop: got %0d want 0", tready_after); end
        tests++; if (got_sum0 !== 32'd32) begin failed++; $display("[TB] FAIL basic_sum: got %0d want 32", got_sum0); end
        tests++; if (got_bc0 !== 32'd4) begin failed++; $display("[TB] FAIL basic_count: got %0d want 4", got_bc0); end
        tests++; if (got_ovf0 !== 0) begin failed++; $display("[TB] FAIL basic_ovf: got %0d want 0", got_ovf0); end
        tests++; if (done_after !== 0) begin failed++; $display("[TB] FAIL basic_done_width: got %0d want 0", done_after); end
    endtask

    task automatic test_tlast_gaps;
        fill_const({B{1'b1}}, 3, 1);
        drive_frame(0, 0, 2, 2, -1);
        tests++; if (timed_out !== 0) begin failed++; $display("[TB] FAIL tlast_timeout: got %0d want 0", timed_out); end
        tests++; if (got_sum0 !== 32'hFFFF_FFE8) begin failed++; $display("[TB] FAIL tlast_sum: got %0d want -24", $signed(got_sum0)); end
        tests++; if (got_bc0 !== 32'd3) begin failed++; $display("[TB] FAIL tlast_count: got %0d want 3", got_bc0); end
    endtask

    task automatic test_square;
        longint e1; bit o1;
        fill_const({LANES{8'h80}}, 2, 0);
        drive_frame(1, 2, 0, 0, -1);
        model_frame(1, 16, 1, e1, o1);
        tests++; if (got_sum0 !== 32'd262144) begin failed++; $display("[TB] FAIL square_sum: got %0d want 262144", got_sum0); end
        tests++; if (got_ovf0 !== 0) begin failed++; $display("[TB] FAIL square_ovf: got %0d want 0", got_ovf0); end
        tests++; if (longint'($signed(got_sum1)) !== e1 || got_ovf1 !== o1) begin failed++; $display("[TB] FAIL square_sat16: got %0d/%0d want %0d/%0d", $signed(got_sum1), got_ovf1, e1, o1); end
    endtask

    task automatic test_saturate;
        fill_const({LANES{8'h80}}, 1, 0);
        drive_frame(1, 1, 0, 0, -1);
        tests++; if (got_sum1 !== 16'h7FFF || got_ovf1 !== 1) begin failed++; $display("[TB] FAIL sat_clamp: got %0d/%0d want 32767/1", got_sum1, got_ovf1); end
        tests++; if (got_sum2 !== 16'h0000 || got_ovf2 !== 1) begin failed++; $display("[TB] FAIL sat_wrap: got %0d/%0d want 0/1", got_sum2, got_ovf2); end
        tests++; if (got_sum0 !== 32'd131072 || got_ovf0 !== 0) begin failed++; $display("[TB] FAIL sat_wide: got %0d/%0d want 131072/0", got_sum0, got_ovf0); end
    endtask

    task automatic test_start_ignored;
        longint e0; bit o0;
        q_data.delete(); q_last.delete();
        for (int i = 0; i < 4; i++) begin
            q_data.push_back({$urandom, $urandom});
            q_last.push_back(0);
        end
        drive_frame(0, 4, 0, 1, 2);
        model_frame(0, 32, 1, e0, o0);
        tests++; if (got_bc0 !== 32'd4) begin failed++; $display("[TB] FAIL restart_count: got %0d want 4", got_bc0); end
        tests++; if (longint'($signed(got_sum0)) !== e0) begin failed++; $display("[TB] FAIL restart_sum: got %0d want %0d", $signed(got_sum0), e0); end
    endtask

    task automatic test_reset_midframe;
        int dones;
        start = 1; mode = 0; num_beats = 8;
        @(posedge clk); #1;
        start = 0; tdata = 64'h0101010101010101; tvalid = 1;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rstn = 0;
        @(posedge clk); #1;
        tests++; if (busy0 !== 0 || tready0 !== 0) begin failed++; $display("[TB] FAIL midreset_busy: got %0d/%0d want 0/0", busy0, tready0); end
        tests++; if (sum0 !== 32'd0 || bc0 !== 32'd0) begin failed++; $display("[TB] FAIL midreset_sum: got %0d/%0d want 0/0", sum0, bc0); end
        rstn = 1; tvalid = 0;
        dones = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done0 || done1 || done2) dones++;
        end
        tests++; if (dones !== 0) begin failed++; $display("[TB] FAIL midreset_done: got %0d want 0", dones); end
    endtask

    task automatic test_back_to_back;
        longint e0, e1; bit o0, o1;
        fill_const({LANES{8'h80}}, 3, 0);
        drive_frame(1, 3, 0, 0, -1);
        tests++; if (got_ovf1 !== 1) begin failed++; $display("[TB] FAIL b2b_first_ovf: got %0d want 1", got_ovf1); end
        q_data.delete(); q_last.delete();
        for (int i = 0; i < 2; i++) begin
            q_data.push_back({$urandom, $urandom});
            q_last.push_back(i == 1);
        end
        drive_frame(0, 0, 0, 0, -1);
        model_frame(0, 32, 1, e0, o0);
        model_frame(0, 16, 1, e1, o1);
        tests++; if (timed_out !== 0) begin failed++; $display("[TB] FAIL b2b_timeout: got %0d want 0", timed_out); end
        tests++; if (longint'($signed(got_sum0)) !== e0 || got_bc0 !== 32'd2) begin failed++; $display("[TB] FAIL b2b_sum: got %0d/%0d want %0d/2", $signed(got_sum0), got_bc0, e0); end
        tests++; if (longint'($signed(got_sum1)) !== e1 || got_ovf1 !== o1) begin failed++; $display("[TB] FAIL b2b_ovf_clear: got %0d/%0d want %0d/%0d", $signed(got_sum1), got_ovf1, e1, o1); end
    endtask

    task automatic test_random;
        for (int f = 0; f < 24; f++) begin
            int len, choice;
            bit m;
            logic [CNT_W-1:0] nb;
            longint e0, e1, e2; bit o0, o1, o2;
            len    = int'($urandom_range(6, 1));
            choice = int'($urandom_range(2, 0));
            m      = 1'($urandom_range(1, 0));
            nb     = (choice == 0) ? '0 : (choice == 1) ? CNT_W'(len) : CNT_W'(len + int'($urandom_range(3, 1)));
            q_data.delete(); q_last.delete();
            for (int i = 0; i < len; i++) begin
                q_data.push_back({$urandom, $urandom});
                q_last.push_back((i == len - 1) && (nb != CNT_W'(len) || $urandom_range(1, 0) == 1));
            end
            drive_frame(m, nb, 0, 2, -1);
            model_frame(m, 32, 1, e0, o0);
            model_frame(m, 16, 1, e1, o1);
            model_frame(m, 16, 0, e2, o2);
            tests++; if (timed_out !== 0 || got_bc0 !== CNT_W'(len)) begin failed++; $display("[TB] FAIL rand_count f%0d: got %0d (timeout %0d) want %0d", f, got_bc0, timed_out, len); end
            tests++; if (longint'($signed(got_sum0)) !== e0 || got_ovf0 !== o0) begin failed++; $display("[TB] FAIL rand_sum32 f%0d: got %0d/%0d want %0d/%0d", f, $signed(got_sum0), got_ovf0, e0, o0); end
            tests++; if (longint'($signed(got_sum1)) !== e1 || got_ovf1 !== o1) begin failed++; $display("[TB] FAIL rand_sat16 f%0d: got %0d/%0d want %0d/%0d", f, $signed(got_sum1), got_ovf1, e1, o1); end
            tests++; if (longint'($signed(got_sum2)) !== e2 || got_ovf2 !== o2) begin failed++; $display("[TB] FAIL rand_wrap16 f%0d: got %0d/%0d want %0d/%0d", f, $signed(got_sum2), got_ovf2, e2, o2); end
        end
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        test_reset;
        test_sum_basic;
        test_tlast_gaps;
        test_square;
        test_saturate;
        test_start_ignored;
        test_reset_midframe;
        test_back_to_back;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
